sample_window: RTL and testbench
================================

# sample_window

Upstream framing stage for the eight-input averaging datapath. It accepts a serial stream of 16-bit samples under a valid/ready handshake and holds the most recent eight in a shift window. It presents the window as eight parallel words `a`..`h` with an `out_valid`/`out_ready` handshake. The window is frozen while a presented window waits to be consumed, so the downstream adder tree and shift stage always see stable operands.

## Interface
- `DATAWIDTH`, 16, width of each sample and of each window word.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  DATAWIDTH  incoming sample.
- `in_valid`  in  1  `in_data` is valid this cycle.
- `in_ready`  out  1  block can accept a sample this cycle; combinational, equal to `!out_valid || out_ready`.
- `block_mode`  in  1  0 = sliding window, 1 = non-overlapping blocks of 8; latched only when idle.
- `clear`  in  1  synchronous flush of the window.
- `a`..`h`  out  DATAWIDTH each  window words; `a` is the oldest sample, `h` the newest.
- `out_valid`  out  1  `a`..`h` form a complete window.
- `out_ready`  in  1  downstream consumes the window this cycle.
- `count`  out  4  number of valid samples in the window, 0..8.

## Operation
- Accept event: `in_valid && in_ready`. Consume event: `out_valid && out_ready`.
- On accept: `b`..`h` shift into `a`..`g`, and `in_data` is written to `h`. `count` increments and saturates at 8.
- The mode register latches `block_mode` on any cycle where `count==0 && !out_valid`. At all other times `block_mode` is ignored.
- State FILL (`count<8`, `out_valid=0`):
  - Accepts shift the window.
  - The accept that makes `count` reach 8 sets `out_valid=1` on the next edge.
- State PRESENT (`out_valid=1`):
  - Window registers are frozen unless a consume occurs in the same cycle.
  - `in_ready` follows `out_ready`.
- Sliding mode, consume without accept: `out_valid` returns to 0 and `count` stays 8. The state becomes WAIT.
- Sliding mode, consume with accept: the window shifts, `out_valid` stays 1 (a new window), and `count` stays 8.
- Sliding mode, state WAIT (`count==8`, `out_valid=0`): the next accept shifts the window and sets `out_valid=1`.
- Block mode, consume without accept: `count` becomes 0, `out_valid` becomes 0, and the state returns to FILL. `a`..`h` keep their stale values.
- Block mode, consume with accept: the sample is the first of the next block. `count` becomes 1 and `out_valid` becomes 0.
- `clear`:
  - Forces `count=0`, `out_valid=0` and `a`..`h`=0 on the next edge.
  - It has priority over accept and consume; a sample offered in the same cycle is dropped.
  - The mode register re-latches on the following cycle.
- No arithmetic on data: samples pass through unmodified at full `DATAWIDTH`.

## Timing
- Reset values: `a`..`h`=0, `count`=0, `out_valid`=0, mode register=0 (sliding).
  - `in_ready` is therefore 1 during and after reset.
- Reset asserted mid-window discards all samples immediately, independent of `clk`.
- Latency: `out_valid` rises on the clock edge that captures the 8th sample, so it is visible in the cycle after that accept.
- Sliding steady state with `out_ready` tied high gives one new window per accepted sample, with no bubbles.
- `out_valid` and `a`..`h` never change while `out_valid && !out_ready`, except under `clear` or `rst`.
- `in_ready` is purely combinational from `out_valid` and `out_ready`. There is no combinational path from `in_valid` to any output.

## Test plan
- Reset, then 8 accepts of 1..8 in sliding mode:
  - `out_valid` rises the cycle after the 8th accept.
  - The window reads `a`=1 through `h`=8, and `count` reads 8.
- Sliding mode, `out_ready` high, then feed 9 and 10:
  - The windows 2..9 and 3..10 appear on consecutive cycles.
  - `out_valid` stays continuously high.
- Backpressure: window 1..8 presented with `out_ready`=0 for 5 cycles while `in_valid`=1 with `in_data`=0xFFFF:
  - `in_ready`=0 throughout, and the window stays 1..8.
  - Raising `out_ready` consumes the window and accepts 0xFFFF, giving a new window of 2..8,0xFFFF.
- Block mode with samples 0x10..0x1F streamed continuously and `out_ready` high:
  - Exactly two windows are produced, 0x10..0x17 and 0x18..0x1F.
  - `count` returns to 0 or 1 after each consume and never shows an overlapping window.
- `clear` asserted together with an accept at `count`=5: next cycle `count`=0, `a`..`h`=0, `out_valid`=0, and the offered sample is lost.
- Async `rst` pulse between clock edges while `out_valid`=1: outputs go to their reset values immediately, without waiting for `clk`.

Source files
------------

// File: rtl/sample_window.sv
// Eight-deep sample window framing a serial stream for the averaging datapath.
// Sliding or non-overlapping block windows, frozen while a presented window is pending.
module sample_window #(
    parameter int DATAWIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 block_mode,
    input  logic                 clear,
    output logic [DATAWIDTH-1:0] a,
    output logic [DATAWIDTH-1:0] b,
    output logic [DATAWIDTH-1:0] c,
    output logic [DATAWIDTH-1:0] d,
    output logic [DATAWIDTH-1:0] e,
    output logic [DATAWIDTH-1:0] f,
    output logic [DATAWIDTH-1:0] g,
    output logic [DATAWIDTH-1:0] h,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           count
);

    logic [DATAWIDTH-1:0] win_p0 [8];
    logic                 vld_p0;
    logic [3:0]           cnt_p0;
    logic                 mode_p0;
    logic                 accept;
    logic                 consume;

    assign in_ready = !vld_p0 || out_ready;
    assign accept   = in_valid && in_ready;
    assign consume  = vld_p0 && out_ready;

    // Stage p0: window shift register and framing control
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) win_p0[i] <= '0;
            vld_p0  <= 1'b0;
            cnt_p0  <= 4'd0;
            mode_p0 <= 1'b0;
        end else begin
            // Mode can only change while nothing is buffered or presented.
            if (cnt_p0 == 4'd0 && !vld_p0) mode_p0 <= block_mode;

            if (clear) begin
                for (int i = 0; i < 8; i++) win_p0[i] <= '0;
                vld_p0 <= 1'b0;
                cnt_p0 <= 4'd0;
            end else begin
                if (accept) begin
                    for (int i = 0; i < 7; i++) win_p0[i] <= win_p0[i+1];
                    win_p0[7] <= in_data;
                end

                if (consume && mode_p0) begin
                    // Block mode: an accompanying sample opens the next block.
                    cnt_p0 <= accept ? 4'd1 : 4'd0;
                    vld_p0 <= 1'b0;
                end else if (consume) begin
                    vld_p0 <= accept;
                end else if (accept) begin
                    if (cnt_p0 >= 4'd7) vld_p0 <= 1'b1;
                    if (cnt_p0 != 4'd8) cnt_p0 <= cnt_p0 + 4'd1;
                end
            end
        end
    end

    assign a         = win_p0[0];
    assign b         = win_p0[1];
    assign c         = win_p0[2];
    assign d         = win_p0[3];
    assign e         = win_p0[4];
    assign f         = win_p0[5];
    assign g         = win_p0[6];
    assign h         = win_p0[7];
    assign out_valid = vld_p0;
    assign count     = cnt_p0;

endmodule

// File: tb/tb_sample_window.sv
// Bench for sample_window: directed vector table, corner sequences, and a
// randomized run against a queue-based reference model.
module tb_sample_window;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        block_mode;
    logic        clear;
    logic [15:0] a, b, c, d, e, f, g, h;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  count;

    sample_window #(.DATAWIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .block_mode(block_mode), .clear(clear),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
        .out_valid(out_valid), .out_ready(out_ready), .count(count)
    );

    always #5 clk = ~clk;

    logic [15:0] dw [8];
    assign dw[0] = a; assign dw[1] = b; assign dw[2] = c; assign dw[3] = d;
    assign dw[4] = e; assign dw[5] = f; assign dw[6] = g; assign dw[7] = h;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [15:0] dat, input logic ordy,
                         input logic clr, input logic bm);
        in_valid   = iv;
        in_data    = dat;
        out_ready  = ordy;
        clear      = clr;
        block_mode = bm;
    endtask

    typedef struct {
        logic        iv;
        logic [15:0] dat;
        logic        ordy;
        logic        clr;
        logic        bm;
        logic        ir;
        logic        ov;
        logic [3:0]  cnt;
        logic [15:0] ea;
        logic [15:0] eh;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic iv, input logic [15:0] dat, input logic ordy,
                       input logic clr, input logic bm, input logic ir, input logic ov,
                       input logic [3:0] cnt, input logic [15:0] ea, input logic [15:0] eh);
        vec_t v;
        v.iv = iv; v.dat = dat; v.ordy = ordy; v.clr = clr; v.bm = bm;
        v.ir = ir; v.ov = ov; v.cnt = cnt; v.ea = ea; v.eh = eh;
        vq.push_back(v);
    endtask

    // Reference model: the window is a queue of the last eight samples.
    logic [15:0] mw[$];
    int          mcnt;
    logic        mov;
    logic        mmode;

    task automatic model_step(input logic iv, input logic [15:0] dat, input logic ordy,
                              input logic clr, input logic bm, output logic ir);
        logic acc, con, nmode;
        ir    = !mov || ordy;
        acc   = iv && ir;
        con   = mov && ordy;
        nmode = (mcnt == 0 && !mov) ? bm : mmode;
        if (clr) begin
            for (int i = 0; i < 8; i++) mw[i] = 16'h0;
            mcnt = 0;
            mov  = 1'b0;
        end else begin
            if (acc) begin
                void'(mw.pop_front());
                mw.push_back(dat);
            end
            if (con && mmode) begin
                mcnt = acc ? 1 : 0;
                mov  = 1'b0;
            end else if (con) begin
                mov = acc;
            end else if (acc) begin
                mcnt = (mcnt >= 8) ? 8 : mcnt + 1;
                mov  = (mcnt == 8);
            end
        end
        mmode = nmode;
    endtask

    initial begin
        logic ir_exp;
        rst = 1'b1;
        drive(0, 16'h0, 0, 0, 0);

        #12;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_count", count, 0);
        chk("reset_a", a, 0);
        chk("reset_h", h, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Sliding fill 1..8, then windows 2..9 and 3..10 with out_ready high
        for (int k = 1; k <= 8; k++)
            add(1, 16'(k), 0, 0, 0, 1, k == 8, 4'(k), (k == 8) ? 16'd1 : 16'd0, 16'(k));
        add(1, 16'd9,  1, 0, 0, 1, 1, 8, 16'd2, 16'd9);
        add(1, 16'd10, 1, 0, 0, 1, 1, 8, 16'd3, 16'd10);
        add(1, 16'h55, 0, 1, 0, 0, 0, 0, 16'd0, 16'd0);
        // Backpressure on window 1..8
        for (int k = 1; k <= 8; k++)
            add(1, 16'(k), 0, 0, 0, 1, k == 8, 4'(k), (k == 8) ? 16'd1 : 16'd0, 16'(k));
        for (int k = 0; k < 5; k++)
            add(1, 16'hFFFF, 0, 0, 0, 0, 1, 8, 16'd1, 16'd8);
        add(1, 16'hFFFF, 1, 0, 0, 1, 1, 8, 16'd2, 16'hFFFF);
        // Consume without accept, then the WAIT accept
        add(0, 16'h0, 1, 0, 0, 1, 0, 8, 16'd2, 16'hFFFF);
        add(1, 16'd7, 0, 0, 0, 1, 1, 8, 16'd3, 16'd7);
        add(0, 16'h0, 0, 1, 1, 0, 0, 0, 16'd0, 16'd0);
        // Block mode stream 0x10..0x1F
        for (int k = 0; k < 16; k++)
            add(1, 16'(16'h10 + k), 1, 0, 1, 1, (k == 7) || (k == 15),
                (k <= 7) ? 4'(k + 1) : 4'(k - 7),
                (k >= 7) ? 16'(16'h10 + k - 7) : 16'd0, 16'(16'h10 + k));
        add(0, 16'h0, 1, 0, 1, 1, 0, 0, 16'h18, 16'h1F);
        add(0, 16'h0, 0, 0, 0, 1, 0, 0, 16'h18, 16'h1F);

        foreach (vq[i]) begin
            drive(vq[i].iv, vq[i].dat, vq[i].ordy, vq[i].clr, vq[i].bm);
            @(negedge clk);
            chk($sformatf("vec%0d_in_ready", i), in_ready, vq[i].ir);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_out_valid", i), out_valid, vq[i].ov);
            chk($sformatf("vec%0d_count", i), count, vq[i].cnt);
            chk($sformatf("vec%0d_a", i), a, vq[i].ea);
            chk($sformatf("vec%0d_h", i), h, vq[i].eh);
        end

        // Clear together with an accept at count 5
        for (int k = 1; k <= 5; k++) begin
            drive(1, 16'(16'h20 + k), 0, 0, 0);
            @(posedge clk); #1;
        end
        chk("pre_clear_count", count, 5);
        drive(1, 16'hABCD, 0, 1, 0);
        @(posedge clk); #1;
        chk("clear_count", count, 0);
        chk("clear_out_valid", out_valid, 0);
        for (int i = 0; i < 8; i++) chk($sformatf("clear_word%0d", i), dw[i], 0);
        drive(0, 16'h0, 0, 0, 0);
        @(posedge clk); #1;
        chk("clear_sample_lost_count", count, 0);
        chk("clear_sample_lost_h", h, 0);

        // Asynchronous reset between edges while a window is presented
        for (int k = 1; k <= 8; k++) begin
            drive(1, 16'(16'h30 + k), 0, 0, 0);
            @(posedge clk); #1;
        end
        drive(0, 16'h0, 0, 0, 0);
        chk("pre_rst_out_valid", out_valid, 1);
        chk("pre_rst_h", h, 16'h38);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_count", count, 0);
        chk("async_rst_a", a, 0);
        chk("async_rst_h", h, 0);
        chk("async_rst_in_ready", in_ready, 1);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_count", count, 0);

        // Randomized run against the model
        mw.delete();
        for (int i = 0; i < 8; i++) mw.push_back(16'h0);
        mcnt  = 0;
        mov   = 1'b0;
        mmode = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            logic iv, ordy, clr, bm;
            logic [15:0] dat;
            iv   = ($urandom_range(0, 3) != 0);
            dat  = 16'($urandom);
            ordy = ($urandom_range(0, 2) != 0);
            clr  = ($urandom_range(0, 60) == 0);
            bm   = 1'($urandom_range(0, 1));
            drive(iv, dat, ordy, clr, bm);
            @(negedge clk);
            model_step(iv, dat, ordy, clr, bm, ir_exp);
            chk($sformatf("rnd%0d_in_ready", n), in_ready, ir_exp);
            @(posedge clk); #1;
            chk($sformatf("rnd%0d_out_valid", n), out_valid, mov);
            chk($sformatf("rnd%0d_count", n), count, 32'(mcnt));
            for (int i = 0; i < 8; i++)
                chk($sformatf("rnd%0d_word%0d", n, i), dw[i], mw[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
